frame_decoder: RTL and testbench

FRAME_DECODER -- requirements
Module: frame_decoder

---
 rtl/frame_decoder.sv | 160 ++++++++++++++++
 tb/tb_frame_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_decoder.sv
// rtl/frame_decoder.sv - serial 8-slot frame decoder with sync hunt, lock tracking and optional parity check
// Optional feature macro: FRAME_DECODER_PARITY_CHECK_EN (enables parity rejection of frames).

module frame_decoder #(
  parameter int LOCK_LOSS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic IN,
  output logic OUT1,
  output logic OUT2,
  output logic OUT3,
  output logic OUT4,
  output logic valid,
  output logic parity_err,
  output logic locked
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    SYNC = 2'd2
  } state_t;

  localparam logic [2:0] LOSS_LIMIT = 3'(LOCK_LOSS);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] hist_q, hist_d;
  logic [3:0] data_q, data_d;
  logic [3:0] out_q, out_d;
  logic [2:0] miss_q, miss_d;
  logic       bad_q, bad_d;
  logic       valid_q, valid_d;
  logic       locked_q, locked_d;
  logic       parity_ok;
  logic       sync_bit_bad;
  logic [2:0] miss_inc;

`ifdef FRAME_DECODER_PARITY_CHECK_EN
  logic perr_q, perr_d;
  // Even parity: D1..D4 plus P must xor to zero.
  assign parity_ok  = ~^{data_q, IN};
  assign parity_err = perr_q;
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Sync field is 1,1,0: slot 2 expects a zero, slots 0 and 1 expect a one.
  assign sync_bit_bad = (IN != (cnt_q != 3'd2));
  assign miss_inc     = miss_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hist_d   = {hist_q[0], IN};
    data_d   = data_q;
    out_d    = out_q;
    miss_d   = miss_q;
    bad_d    = bad_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
`ifdef FRAME_DECODER_PARITY_CHECK_EN
    perr_d   = 1'b0;
`endif
    case (state_q)
      HUNT: begin
        if ({hist_q, IN} == 3'b110) begin
          state_d = DATA;
          cnt_d   = 3'd0;
        end
      end
      DATA: begin
        if (cnt_q != 3'd4) begin
          data_d = {data_q[2:0], IN};
          cnt_d  = cnt_q + 3'd1;
        end else begin
          cnt_d = 3'd0;
          bad_d = 1'b0;
          if (parity_ok) begin
            out_d    = data_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            if (!locked_q) miss_d = 3'd0;
            state_d  = SYNC;
          end else begin
`ifdef FRAME_DECODER_PARITY_CHECK_EN
            perr_d  = 1'b1;
`endif
            state_d = locked_q ? SYNC : HUNT;
          end
        end
      end
      SYNC: begin
        if (cnt_q != 3'd2) begin
          bad_d = bad_q | sync_bit_bad;
          cnt_d = cnt_q + 3'd1;
        end else begin
          cnt_d = 3'd0;
          bad_d = 1'b0;
          if (bad_q | sync_bit_bad) begin
            // The sync bits just seen stay in hist_q so HUNT can reuse them.
            if (miss_inc == LOSS_LIMIT) begin
              miss_d   = 3'd0;
              locked_d = 1'b0;
              state_d  = HUNT;
            end else begin
              miss_d  = miss_inc;
              state_d = DATA;
            end
          end else begin
            miss_d  = 3'd0;
            state_d = DATA;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= HUNT;
      cnt_q    <= 3'd0;
      hist_q   <= 2'b00;
      data_q   <= 4'd0;
      out_q    <= 4'd0;
      miss_q   <= 3'd0;
      bad_q    <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hist_q   <= hist_d;
      data_q   <= data_d;
      out_q    <= out_d;
      miss_q   <= miss_d;
      bad_q    <= bad_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

`ifdef FRAME_DECODER_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end
`endif

  assign OUT1   = out_q[3];
  assign OUT2   = out_q[2];
  assign OUT3   = out_q[1];
  assign OUT4   = out_q[0];
  assign valid  = valid_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_frame_decoder.sv
// tb/tb_frame_decoder.sv - directed and randomized bench for frame_decoder with a stream-index reference model
// Honours FRAME_DECODER_PARITY_CHECK_EN the same way as the design.

module tb_frame_decoder;

  localparam int LL = 2;

  logic clk = 1'b0;
  logic reset;
  logic IN;
  logic o1, o2, o3, o4;
  logic valid, perr, locked;

  frame_decoder #(.LOCK_LOSS(LL)) dut (
    .clk(clk), .reset(reset), .IN(IN),
    .OUT1(o1), .OUT2(o2), .OUT3(o3), .OUT4(o4),
    .valid(valid), .parity_err(perr), .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: the raw bit stream since reset plus the index of the current frame's slot 0.
  bit         q[$];
  int         anchor;
  bit         hunting;
  bit         m_locked;
  bit         m_valid;
  bit         m_perr;
  int         miss;
  logic [3:0] m_out;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    anchor   = 0;
    hunting  = 1'b1;
    m_locked = 1'b0;
    m_valid  = 1'b0;
    m_perr   = 1'b0;
    miss     = 0;
    m_out    = 4'd0;
  endtask

  task automatic model_bit(input bit b);
    int n;
    int pos;
    logic [3:0] d;
    bit ok;
    q.push_back(b);
    n = q.size() - 1;
    m_valid = 1'b0;
    m_perr  = 1'b0;
    if (hunting) begin
      if (n >= 2 && q[n-2] && q[n-1] && !q[n]) begin
        hunting = 1'b0;
        anchor  = n - 2;
      end
    end else begin
      pos = n - anchor;
      if (pos == 2 && m_locked) begin
        if (q[anchor] && q[anchor+1] && !q[anchor+2]) miss = 0;
        else begin
          miss++;
          if (miss >= LL) begin
            miss     = 0;
            m_locked = 1'b0;
            hunting  = 1'b1;
          end
        end
      end else if (pos == 7) begin
        d = {q[anchor+3], q[anchor+4], q[anchor+5], q[anchor+6]};
`ifdef FRAME_DECODER_PARITY_CHECK_EN
        ok = ((d[0] ^ d[1] ^ d[2] ^ d[3]) == q[anchor+7]);
`else
        ok = 1'b1;
`endif
        if (ok) begin
          m_out    = d;
          m_valid  = 1'b1;
          if (!m_locked) miss = 0;
          m_locked = 1'b1;
          anchor   = anchor + 8;
        end else begin
          m_perr = 1'b1;
          if (m_locked) anchor = anchor + 8;
          else hunting = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check1("valid", valid, m_valid);
    check1("parity_err", perr, m_perr);
    check4("out", {o1, o2, o3, o4}, m_out);
    check1("locked", locked, m_locked);
    check1("exclusive", valid & perr, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    IN    = 1'($urandom);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    compare_all();
  endtask

  task automatic step(input bit b);
    IN = b;
    model_bit(b);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [7:0] fr);
    for (int i = 7; i >= 0; i--) step(fr[i]);
  endtask

  logic [7:0] fr;
  logic [3:0] d;
  int kind;
  int ngarb;

  initial begin
    reset = 1'b1;
    IN    = 1'b0;
    model_reset();
    do_reset();
    check4("reset_out", {o1, o2, o3, o4}, 4'b0000);
    check1("reset_locked", locked, 1'b0);

    // Good first frame from HUNT.
    send_frame(8'b11010111);
    check1("r029_valid", valid, 1'b1);
    check4("r029_out", {o1, o2, o3, o4}, 4'b1011);
    check1("r029_locked", locked, 1'b1);

    // Bad-parity frame from HUNT.
    do_reset();
    send_frame(8'b11010110);
`ifdef FRAME_DECODER_PARITY_CHECK_EN
    check1("r030_perr", perr, 1'b1);
    check1("r030_valid", valid, 1'b0);
    check4("r030_out", {o1, o2, o3, o4}, 4'b0000);
    check1("r030_locked", locked, 1'b0);
    step(1'b1);
    check1("r030_perr_pulse", perr, 1'b0);
`else
    check1("r034_valid", valid, 1'b1);
    check4("r034_out", {o1, o2, o3, o4}, 4'b1011);
    check1("r034_perr", perr, 1'b0);
`endif

    // Leading garbage then a frame.
    do_reset();
    step(1'b0); step(1'b0); step(1'b1); step(1'b0);
    send_frame(8'b11001100);
    check1("r031_valid", valid, 1'b1);
    check4("r031_out", {o1, o2, o3, o4}, 4'b0110);

    // One bad sync tolerated, the next consecutive bad sync drops lock.
    send_frame(8'b10011110);
    check1("r032_valid", valid, 1'b1);
    check4("r032_out", {o1, o2, o3, o4}, 4'b1111);
    check1("r032_locked", locked, 1'b1);
    step(1'b0); step(1'b0);
    check1("r032_locked_mid", locked, 1'b1);
    step(1'b0);
    check1("r032_lost", locked, 1'b0);

    // Reset at slot 5 of a frame.
    step(1'b1); step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    do_reset();
    check1("r033_valid", valid, 1'b0);
    check4("r033_out", {o1, o2, o3, o4}, 4'b0000);
    check1("r033_locked", locked, 1'b0);
    send_frame(8'b11001100);
    check1("r033_next_valid", valid, 1'b1);
    check4("r033_next_out", {o1, o2, o3, o4}, 4'b0110);

    // Randomized mix of clean frames, corrupted syncs, parity errors, garbage and resets.
    for (int k = 0; k < 200; k++) begin
      kind = $urandom_range(0, 11);
      if (kind == 0) do_reset();
      d  = 4'($urandom);
      fr = {3'b110, d, d[0] ^ d[1] ^ d[2] ^ d[3]};
      if (kind == 1 || kind == 2) fr[$urandom_range(5, 7)] ^= 1'b1;
      if (kind == 3) fr[0] ^= 1'b1;
      if (kind == 4) begin
        ngarb = $urandom_range(1, 6);
        for (int g = 0; g < ngarb; g++) step(1'($urandom));
      end
      if (kind == 5) fr = 8'($urandom);
      send_frame(fr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
